// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with fully registered position, sync, blanking and strobe outputs.
// Define VGA_TIMING_ADJ_EN to add a runtime active-resolution change with a valid/ready handshake.
module vga_timing_gen #(
   parameter int HRES = 640,
   parameter int HF   = 16,
   parameter int HS   = 96,
   parameter int HB   = 48,
   parameter int VRES = 480,
   parameter int VF   = 10,
   parameter int VS   = 2,
   parameter int VB   = 33,
   parameter int HPOL = 0,
   parameter int VPOL = 0,
   parameter int CW   = 10,
   parameter int FW   = 11
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pix_en,
   output logic [CW-1:0] o_h,
   output logic [CW-1:0] o_v,
   output logic [FW-1:0] o_frame,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_hblank,
   output logic          o_vblank,
   output logic          o_visible,
   output logic          o_line_start,
   output logic          o_frame_start
`ifdef VGA_TIMING_ADJ_EN
   ,
   input  logic          i_cfg_valid,
   input  logic [CW-1:0] i_cfg_hres,
   input  logic [CW-1:0] i_cfg_vres,
   output logic          o_cfg_ready
`endif
);

   localparam logic          C_HACT   = (HPOL != 0) ? 1'b1 : 1'b0;
   localparam logic          C_VACT   = (VPOL != 0) ? 1'b1 : 1'b0;
   localparam logic [CW-1:0] C_HTAIL  = CW'(HF + HS + HB);
   localparam logic [CW-1:0] C_VTAIL  = CW'(VF + VS + VB);

   logic [CW-1:0] r_h, r_v;
   logic [FW-1:0] r_frame;
   logic          r_hsync, r_vsync, r_hblank, r_vblank, r_visible;
   logic          r_line_start, r_frame_start;

   logic [CW-1:0] w_cur_hres, w_cur_vres, w_nxt_hres, w_nxt_vres;
   logic [CW-1:0] w_h_nxt, w_v_nxt;
   logic          w_h_wrap, w_v_wrap, w_frame_wrap;
   logic          w_hs_on, w_vs_on;

`ifdef VGA_TIMING_ADJ_EN
   logic [CW-1:0] r_cur_hres, r_cur_vres, r_pend_hres, r_pend_vres;
   logic          r_cfg_ready;
   logic          w_apply;

   assign w_cur_hres = r_cur_hres;
   assign w_cur_vres = r_cur_vres;
   // Pending geometry only lands on an enabled frame-wrap step, never on the accept step itself.
   assign w_apply    = i_pix_en && w_frame_wrap && !r_cfg_ready;
   assign w_nxt_hres = w_apply ? r_pend_hres : r_cur_hres;
   assign w_nxt_vres = w_apply ? r_pend_vres : r_cur_vres;
   assign o_cfg_ready = r_cfg_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cur_hres  <= CW'(HRES);
         r_cur_vres  <= CW'(VRES);
         r_pend_hres <= '0;
         r_pend_vres <= '0;
         r_cfg_ready <= 1'b1;
      end else if (w_apply) begin
         r_cur_hres  <= r_pend_hres;
         r_cur_vres  <= r_pend_vres;
         r_cfg_ready <= 1'b1;
      end else if (i_cfg_valid && r_cfg_ready) begin
         r_pend_hres <= i_cfg_hres;
         r_pend_vres <= i_cfg_vres;
         r_cfg_ready <= 1'b0;
      end
   end
`else
   assign w_cur_hres = CW'(HRES);
   assign w_cur_vres = CW'(VRES);
   assign w_nxt_hres = CW'(HRES);
   assign w_nxt_vres = CW'(VRES);
`endif

   // All-ones also wraps so that an upset counter beyond the last column/line recovers.
   assign w_h_wrap     = (r_h == (w_cur_hres + C_HTAIL - CW'(1))) || (&r_h);
   assign w_v_wrap     = (r_v == (w_cur_vres + C_VTAIL - CW'(1))) || (&r_v);
   assign w_frame_wrap = w_h_wrap && w_v_wrap;
   assign w_h_nxt      = w_h_wrap ? '0 : (r_h + CW'(1));
   assign w_v_nxt      = w_h_wrap ? (w_v_wrap ? '0 : (r_v + CW'(1))) : r_v;

   assign w_hs_on = (w_h_nxt >= (w_nxt_hres + CW'(HF))) && (w_h_nxt < (w_nxt_hres + CW'(HF + HS)));
   assign w_vs_on = (w_v_nxt >= (w_nxt_vres + CW'(VF))) && (w_v_nxt < (w_nxt_vres + CW'(VF + VS)));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_h           <= '0;
         r_v           <= '0;
         r_frame       <= '0;
         r_hsync       <= ~C_HACT;
         r_vsync       <= ~C_VACT;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_visible     <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (i_pix_en) begin
         r_h           <= w_h_nxt;
         r_v           <= w_v_nxt;
         r_frame       <= w_frame_wrap ? (r_frame + FW'(1)) : r_frame;
         r_hsync       <= w_hs_on ? C_HACT : ~C_HACT;
         r_vsync       <= w_vs_on ? C_VACT : ~C_VACT;
         r_hblank      <= (w_h_nxt >= w_nxt_hres);
         r_vblank      <= (w_v_nxt >= w_nxt_vres);
         r_visible     <= (w_h_nxt < w_nxt_hres) && (w_v_nxt < w_nxt_vres);
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_frame_wrap;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign o_h           = r_h;
   assign o_v           = r_v;
   assign o_frame       = r_frame;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_hblank      = r_hblank;
   assign o_vblank      = r_vblank;
   assign o_visible     = r_visible;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen on a 12x7 total raster (8x4 active).
// Runs the runtime resolution scenario when VGA_TIMING_ADJ_EN is defined.
module tb_vga_timing_gen;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pix_en = 1'b1;
   logic [CW-1:0] h, v, h2, v2;
   logic [10:0]   frame;
   logic [1:0]    frame2;
   logic          hs, vs, hb, vb, vis, ls, fs;
   logic          hs2, vs2, hb2, vb2, vis2, ls2, fs2;
   logic          cfg_valid = 1'b0;
   logic [CW-1:0] cfg_hres = 4'd0, cfg_vres = 4'd0;
   logic          cfg_ready, cfg_ready2;

   int chk = 0, fails = 0;
   int eh, ev, ef, nls, nfs;
   logic [14:0] exp_v;

   wire [14:0] obs  = {h, v, hs, vs, hb, vb, vis, ls, fs};
   wire [14:0] obs2 = {h2, v2, hs2, vs2, hb2, vb2, vis2, ls2, fs2};

   always #5 clk = ~clk;

   vga_timing_gen #(.HRES(8), .HF(1), .HS(2), .HB(1), .VRES(4), .VF(1), .VS(1), .VB(1),
                    .HPOL(0), .VPOL(0), .CW(CW), .FW(11)) dut (
      .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .o_h(h), .o_v(v), .o_frame(frame),
      .o_hsync(hs), .o_vsync(vs), .o_hblank(hb), .o_vblank(vb), .o_visible(vis),
      .o_line_start(ls), .o_frame_start(fs)
`ifdef VGA_TIMING_ADJ_EN
      , .i_cfg_valid(cfg_valid), .i_cfg_hres(cfg_hres), .i_cfg_vres(cfg_vres), .o_cfg_ready(cfg_ready)
`endif
   );

   vga_timing_gen #(.HRES(8), .HF(1), .HS(2), .HB(1), .VRES(4), .VF(1), .VS(1), .VB(1),
                    .HPOL(1), .VPOL(1), .CW(CW), .FW(2)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .o_h(h2), .o_v(v2), .o_frame(frame2),
      .o_hsync(hs2), .o_vsync(vs2), .o_hblank(hb2), .o_vblank(vb2), .o_visible(vis2),
      .o_line_start(ls2), .o_frame_start(fs2)
`ifdef VGA_TIMING_ADJ_EN
      , .i_cfg_valid(cfg_valid), .i_cfg_hres(cfg_hres), .i_cfg_vres(cfg_vres), .o_cfg_ready(cfg_ready2)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic adv(input int hfull, input int vfull);
      if (eh == hfull - 1) begin
         eh = 0;
         if (ev == vfull - 1) begin ev = 0; ef = ef + 1; end
         else ev = ev + 1;
      end else begin
         eh = eh + 1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; pix_en = 1'b1;
      step();
      reset = 1'b0;
      eh = 0; ev = 0; ef = 0; nls = 0; nfs = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pix_en = 1'b1;
      step(); step();
      chk++;
      if (obs !== 15'b0000_0000_1100100) begin
         fails++; $display("FAIL reset_outputs: got %h expected %h", obs, 15'b0000_0000_1100100);
      end
      chk++;
      if (obs2 !== 15'b0000_0000_0000100) begin
         fails++; $display("FAIL reset_outputs_pol1: got %h expected %h", obs2, 15'b0000_0000_0000100);
      end
      chk++;
      if (frame !== 11'd0) begin fails++; $display("FAIL reset_frame: got %0d expected 0", frame); end
`ifdef VGA_TIMING_ADJ_EN
      chk++;
      if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
`endif
      reset = 1'b0;
      eh = 0; ev = 0; ef = 0;
   endtask

   // T1: first line after release, including no strobe on the release step
   task automatic test_line();
      for (int i = 0; i < 12; i++) begin
         step(); adv(12, 7);
         exp_v = {4'(eh), 4'(ev), !(eh == 9 || eh == 10), !(ev == 5), eh >= 8, ev >= 4,
                  (eh < 8) && (ev < 4), eh == 0, (eh == 0) && (ev == 0)};
         chk++;
         if (obs !== exp_v) begin fails++; $display("FAIL line step%0d: got %h expected %h", i, obs, exp_v); end
      end
   endtask

   // T2: one complete frame of 84 enabled steps
   task automatic test_frame();
      do_reset();
      for (int i = 0; i < 84; i++) begin
         step(); adv(12, 7);
         if (ls === 1'b1) nls++;
         if (fs === 1'b1) nfs++;
         exp_v = {4'(eh), 4'(ev), !(eh == 9 || eh == 10), !(ev == 5), eh >= 8, ev >= 4,
                  (eh < 8) && (ev < 4), eh == 0, (eh == 0) && (ev == 0)};
         chk++;
         if (obs !== exp_v) begin fails++; $display("FAIL frame step%0d: got %h expected %h", i, obs, exp_v); end
         chk++;
         if (frame !== 11'(ef)) begin fails++; $display("FAIL frame_count step%0d: got %0d expected %0d", i, frame, ef); end
      end
      chk++;
      if (nls != 7) begin fails++; $display("FAIL line_start_count: got %0d expected 7", nls); end
      chk++;
      if (nfs != 1) begin fails++; $display("FAIL frame_start_count: got %0d expected 1", nfs); end
      chk++;
      if (frame !== 11'd1) begin fails++; $display("FAIL frame_after_84: got %0d expected 1", frame); end
   endtask

   // T3: pix_en alternating; strobes must clear on disabled clocks
   task automatic test_pix_en();
      do_reset();
      for (int k = 0; k < 30; k++) begin
         pix_en = (k % 2 == 0);
         step();
         if (pix_en) adv(12, 7);
         exp_v = {4'(eh), 4'(ev), !(eh == 9 || eh == 10), !(ev == 5), eh >= 8, ev >= 4,
                  (eh < 8) && (ev < 4), pix_en && (eh == 0), pix_en && (eh == 0) && (ev == 0)};
         chk++;
         if (obs !== exp_v) begin fails++; $display("FAIL pix_en clk%0d: got %h expected %h", k, obs, exp_v); end
      end
      pix_en = 1'b1;
   endtask

   // T4: asynchronous reset in the middle of line 2
   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 29; i++) begin step(); adv(12, 7); end
      chk++;
      if (h !== 4'd5 || v !== 4'd2) begin fails++; $display("FAIL mid_position: got h=%0d v=%0d expected h=5 v=2", h, v); end
      #2 reset = 1'b1;
      #1;
      chk++;
      if (obs !== 15'b0000_0000_1100100) begin
         fails++; $display("FAIL async_reset: got %h expected %h", obs, 15'b0000_0000_1100100);
      end
      step(); step();
      chk++;
      if (obs !== 15'b0000_0000_1100100) begin
         fails++; $display("FAIL reset_hold: got %h expected %h", obs, 15'b0000_0000_1100100);
      end
      reset = 1'b0;
      step();
      chk++;
      if (obs !== 15'b0001_0000_1100100) begin
         fails++; $display("FAIL release_no_strobe: got %h expected %h", obs, 15'b0001_0000_1100100);
      end
   endtask

   // T5: inverted sync polarity and 2-bit frame counter wrapping 3 -> 0
   task automatic test_polarity();
      do_reset();
      for (int i = 0; i < 340; i++) begin
         step(); adv(12, 7);
         exp_v = {4'(eh), 4'(ev), eh == 9 || eh == 10, ev == 5, eh >= 8, ev >= 4,
                  (eh < 8) && (ev < 4), eh == 0, (eh == 0) && (ev == 0)};
         chk++;
         if (obs2 !== exp_v) begin fails++; $display("FAIL pol step%0d: got %h expected %h", i, obs2, exp_v); end
         chk++;
         if (frame2 !== 2'(ef % 4)) begin fails++; $display("FAIL pol_frame step%0d: got %0d expected %0d", i, frame2, ef % 4); end
      end
      chk++;
      if (frame2 !== 2'd0 || frame !== 11'd4) begin
         fails++; $display("FAIL frame_wrap: got %0d/%0d expected 0/4", frame2, frame);
      end
   endtask

`ifdef VGA_TIMING_ADJ_EN
   // T6: request 6x3 mid-frame, second request while busy must be ignored
   task automatic test_adj();
      do_reset();
      for (int i = 0; i < 20; i++) begin step(); adv(12, 7); end
      cfg_valid = 1'b1; cfg_hres = 4'd6; cfg_vres = 4'd3;
      step(); adv(12, 7);
      chk++;
      if (cfg_ready !== 1'b0) begin fails++; $display("FAIL cfg_accept: got %b expected 0", cfg_ready); end
      cfg_hres = 4'd5; cfg_vres = 4'd2;
      step(); adv(12, 7);
      cfg_valid = 1'b0;
      for (int i = 0; i < 62; i++) begin
         step(); adv(12, 7);
         chk++;
         if (cfg_ready !== ((eh == 0) && (ev == 0)) || h !== 4'(eh) || fs !== ((eh == 0) && (ev == 0))) begin
            fails++; $display("FAIL cfg_pending step%0d: got rdy=%b h=%0d fs=%b expected h=%0d", i, cfg_ready, h, fs, eh);
         end
      end
      for (int i = 0; i < 60; i++) begin
         step(); adv(10, 6);
         exp_v = {4'(eh), 4'(ev), !(eh == 7 || eh == 8), !(ev == 4), eh >= 6, ev >= 3,
                  (eh < 6) && (ev < 3), eh == 0, (eh == 0) && (ev == 0)};
         chk++;
         if (obs !== exp_v || cfg_ready !== 1'b1) begin
            fails++; $display("FAIL adj step%0d: got %h rdy=%b expected %h rdy=1", i, obs, cfg_ready, exp_v);
         end
      end
      chk++;
      if (frame !== 11'd2) begin fails++; $display("FAIL adj_frame: got %0d expected 2", frame); end
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_pix_en();
      test_reset_mid();
      test_polarity();
`ifdef VGA_TIMING_ADJ_EN
      test_adj();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
      $finish;
   end

endmodule
